// File: rtl/sysid_read_arbiter.sv
// Two-master round-robin read arbiter in front of the system-ID control slave.
// Optional read cache enabled by defining SYSID_ARB_CACHE_EN.
module sysid_read_arbiter #(
    parameter int unsigned SLAVE_LATENCY = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m0_read,
    input  logic        m0_address,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic        m1_read,
    input  logic        m1_address,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        s_read,
    output logic        s_address,
    input  logic [31:0] s_readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant;
    logic               r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rdata;
    logic               r_s_address;

    logic               w_pick;
    logic               w_addr;
    logic               w_start;
    logic               w_finish;
    logic               w_hit;

`ifdef SYSID_ARB_CACHE_EN
    logic [31:0]        r_cache [2];
    logic [1:0]         r_valid;
`endif

    always_comb begin
        w_hit       = 1'b0;
        // Contention goes to the master that did not win last; otherwise the sole requester.
        w_pick      = (m0_read & m1_read) ? ~r_last_grant : m1_read;
        w_addr      = w_pick ? m1_address : m0_address;
        w_start     = (r_state == IDLE) && (m0_read || m1_read);
        w_finish    = (r_state == ACCESS) && (r_cnt == CNT_W'(1));
`ifdef SYSID_ARB_CACHE_EN
        w_hit       = r_valid[w_addr];
`endif
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = w_hit ? DONE : ACCESS;
            ACCESS:  if (w_finish) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_s_address  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_grant     <= w_pick;
                r_s_address <= w_addr;
                r_cnt       <= CNT_W'(SLAVE_LATENCY);
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_rdata      <= s_readdata;
                r_last_grant <= r_grant;
            end
`ifdef SYSID_ARB_CACHE_EN
            if (w_start && w_hit) begin
                r_rdata      <= r_cache[w_addr];
                r_last_grant <= w_pick;
            end
`endif
        end
    end

`ifdef SYSID_ARB_CACHE_EN
    // Fill happens on the same edge that rdata captures the slave word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (w_finish) begin
            r_valid[r_s_address] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_finish) begin
            r_cache[r_s_address] <= s_readdata;
        end
    end
`endif

    assign s_read         = (r_state == ACCESS);
    assign s_address      = r_s_address;
    assign m0_waitrequest = m0_read & ~((r_state == DONE) & ~r_grant);
    assign m1_waitrequest = m1_read & ~((r_state == DONE) &  r_grant);
    assign m0_readdata    = r_rdata;
    assign m1_readdata    = r_rdata;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Self-checking bench: two arbiters (latency 1 and 4) share one stimulus stream
// and are compared every cycle against a transaction-level timing model.
module tb_sysid_read_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_read = 1'b0, m0_address = 1'b0;
    logic        m1_read = 1'b0, m1_address = 1'b0;
    logic [1:0]  wait0, wait1, sread, saddr;
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [31:0] srd [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] slave_data(input logic a);
        return a ? 32'h52445A22 : 32'h00000000;
    endfunction

    assign srd[0] = slave_data(saddr[0]);
    assign srd[1] = slave_data(saddr[1]);

    sysid_read_arbiter #(.SLAVE_LATENCY(1), .CNT_W(4)) dut_l1 (
        .clock(clock), .reset_n(reset_n),
        .m0_read(m0_read), .m0_address(m0_address),
        .m0_waitrequest(wait0[0]), .m0_readdata(rd0[0]),
        .m1_read(m1_read), .m1_address(m1_address),
        .m1_waitrequest(wait1[0]), .m1_readdata(rd1[0]),
        .s_read(sread[0]), .s_address(saddr[0]), .s_readdata(srd[0])
    );

    sysid_read_arbiter #(.SLAVE_LATENCY(4), .CNT_W(4)) dut_l4 (
        .clock(clock), .reset_n(reset_n),
        .m0_read(m0_read), .m0_address(m0_address),
        .m0_waitrequest(wait0[1]), .m0_readdata(rd0[1]),
        .m1_read(m1_read), .m1_address(m1_address),
        .m1_waitrequest(wait1[1]), .m1_readdata(rd1[1]),
        .s_read(sread[1]), .s_address(saddr[1]), .s_readdata(srd[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding transfer per instance, described by
    // winner, address, and the cycle in which it completes.
    int          lat     [2] = '{1, 4};
    bit          m_act   [2] = '{0, 0};
    bit          m_win   [2];
    bit          m_addr  [2];
    bit          m_hit   [2];
    bit          m_last  [2] = '{1, 1};
    int          m_done  [2];
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
    bit          m_valid [2][2];

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            bit e_sread, e_w0, e_w1, cache_on;
            cache_on = 1'b0;
`ifdef SYSID_ARB_CACHE_EN
            cache_on = 1'b1;
`endif
            if (m_act[k] && cyc == m_done[k]) begin
                m_rdata[k] = slave_data(m_addr[k]);
                m_valid[k][m_addr[k]] = 1'b1;
            end
            e_sread = m_act[k] && !m_hit[k] && cyc >= m_done[k] - lat[k] && cyc < m_done[k];
            e_w0 = m0_read && !(m_act[k] && cyc == m_done[k] && m_win[k] == 1'b0);
            e_w1 = m1_read && !(m_act[k] && cyc == m_done[k] && m_win[k] == 1'b1);
            check($sformatf("d%0d m0_wait c%0d", k, cyc), 32'(wait0[k]), 32'(e_w0));
            check($sformatf("d%0d m1_wait c%0d", k, cyc), 32'(wait1[k]), 32'(e_w1));
            check($sformatf("d%0d m0_rdata c%0d", k, cyc), rd0[k], m_rdata[k]);
            check($sformatf("d%0d m1_rdata c%0d", k, cyc), rd1[k], m_rdata[k]);
            check($sformatf("d%0d s_read c%0d", k, cyc), 32'(sread[k]), 32'(e_sread));
            if (e_sread)
                check($sformatf("d%0d s_addr c%0d", k, cyc), 32'(saddr[k]), 32'(m_addr[k]));

            if (!reset_n) begin
                m_act[k]   = 1'b0;
                m_last[k]  = 1'b1;
                m_rdata[k] = '0;
                m_valid[k] = '{0, 0};
            end else if (m_act[k] && cyc == m_done[k]) begin
                m_act[k] = 1'b0;
            end else if (!m_act[k] && (m0_read || m1_read)) begin
                m_win[k]  = (m0_read && m1_read) ? !m_last[k] : m1_read;
                m_addr[k] = m_win[k] ? m1_address : m0_address;
                m_hit[k]  = cache_on && m_valid[k][m_addr[k]];
                m_done[k] = m_hit[k] ? cyc + 1 : cyc + 1 + lat[k];
                m_last[k] = m_win[k];
                m_act[k]  = 1'b1;
            end
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        next();
        reset_n = 1'b0;
        m0_read = 1'b0;
        m1_read = 1'b0;
        next();
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        next();
        m0_read = 1'b0;
        m1_read = 1'b0;
        repeat (n) next();
    endtask

    initial begin
        logic w0, w1;
        next();
        next();

        // Lone m0 read of address 1
        do_reset();
        m0_read = 1'b1; m0_address = 1'b1;
        adv(1);
        check("A s_read c1", 32'(sread[0]), 32'd1);
        check("A s_addr c1", 32'(saddr[0]), 32'd1);
        adv(1);
        check("A m0_wait c2", 32'(wait0[0]), 32'd0);
        check("A m0_rdata c2", rd0[0], 32'h52445A22);
        check("A m1_wait c2", 32'(wait1[0]), 32'd0);
        idle(6);

        // Repeat read: cache hit or full access
        m0_read = 1'b1; m0_address = 1'b1;
        adv(1);
`ifdef SYSID_ARB_CACHE_EN
        check("B m0_wait c1", 32'(wait0[0]), 32'd0);
        check("B m0_rdata c1", rd0[0], 32'h52445A22);
        check("B s_read c1", 32'(sread[0]), 32'd0);
`else
        check("B m0_wait c1", 32'(wait0[0]), 32'd1);
        check("B s_read c1", 32'(sread[0]), 32'd1);
        adv(1);
        check("B m0_wait c2", 32'(wait0[0]), 32'd0);
        check("B m0_rdata c2", rd0[0], 32'h52445A22);
`endif
        idle(6);

        // Simultaneous requests after reset: m0 first
        do_reset();
        m0_read = 1'b1; m0_address = 1'b0;
        m1_read = 1'b1; m1_address = 1'b1;
        adv(2);
        check("C m0_wait c2", 32'(wait0[0]), 32'd0);
        check("C m0_rdata c2", rd0[0], 32'h00000000);
        check("C m1_wait c2", 32'(wait1[0]), 32'd1);
        adv(3);
        check("C m1_wait c5", 32'(wait1[0]), 32'd0);
        check("C m1_rdata c5", rd1[0], 32'h52445A22);
        check("C l4 m0_wait c5", 32'(wait0[1]), 32'd0);
        idle(8);

        // Held contention alternates grants
        do_reset();
        m0_read = 1'b1; m0_address = 1'b0;
        m1_read = 1'b1; m1_address = 1'b1;
`ifndef SYSID_ARB_CACHE_EN
        for (int i = 0; i < 6; i++) begin
            adv(i == 0 ? 2 : 3);
            if (i % 2 == 0) check($sformatf("D xfer%0d m0_wait", i), 32'(wait0[0]), 32'd0);
            else            check($sformatf("D xfer%0d m1_wait", i), 32'(wait1[0]), 32'd0);
        end
`else
        adv(17);
`endif
        idle(12);

        // Reset during an m1 access, then re-grant
        do_reset();
        m1_read = 1'b1; m1_address = 1'b1;
        next();
        reset_n = 1'b0;
        adv(0);
        check("E s_read c1", 32'(sread[0]), 32'd1);
        next();
        reset_n = 1'b1;
        adv(0);
        check("E s_read c2", 32'(sread[0]), 32'd0);
        check("E m1_wait c2", 32'(wait1[0]), 32'd1);
        check("E m1_rdata c2", rd1[0], 32'h0);
        adv(2);
        check("E m1_wait c4", 32'(wait1[0]), 32'd0);
        check("E m1_rdata c4", rd1[0], 32'h52445A22);
        idle(8);

        // Latency 4 instance, m1 addr 0
        do_reset();
        m1_read = 1'b1; m1_address = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            adv(1);
            check($sformatf("F l4 s_read c%0d", i), 32'(sread[1]), 32'd1);
        end
        adv(1);
        check("F l4 m1_wait c5", 32'(wait1[1]), 32'd0);
        idle(8);

        // Randomised traffic with occasional drops and resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            w0 = wait0[0];
            w1 = wait1[0];
            next();
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
            if (!m0_read || !w0) begin
                m0_read = 1'($urandom_range(0, 1));
                m0_address = 1'($urandom);
            end else if ($urandom_range(0, 49) == 0) begin
                m0_read = 1'b0;
            end
            if (!m1_read || !w1) begin
                m1_read = 1'($urandom_range(0, 1));
                m1_address = 1'($urandom);
            end else if ($urandom_range(0, 49) == 0) begin
                m1_read = 1'b0;
            end
        end
        reset_n = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
